mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/pipe_cpu_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_cpu_pkg.sv
// Shared definitions for the pipelined CPU memory subsystem: arbiter FSM
// encoding, default timing parameters and the latched transaction record.
package pipe_cpu_pkg;

   localparam int LAT_DEFAULT        = 2;
   localparam int STARVE_MAX_DEFAULT = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef struct packed {
      logic        is_dm;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_txn_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority decision between the fetch and data ports, with a
// starvation override that lets a waiting fetch through after STARVE_MAX data grants.
module mem_arb_pick
   import pipe_cpu_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic       if_req,
   input  logic       dm_req,
   input  logic       flush,
   input  logic [3:0] starve_cnt,
   output logic       grant_if,
   output logic       grant_dm
);

   logic fetch_ok;

   // A flush kills the fetch candidate outright, so data can still win that cycle.
   assign fetch_ok = if_req & ~flush;
   assign grant_if = fetch_ok & (~dm_req | (starve_cnt == 4'(STARVE_MAX)));
   assign grant_dm = dm_req & ~grant_if;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access.
// One transaction at a time: IDLE -> ISSUE -> WAIT (LAT cycles) -> RESP.
module mem_arbiter
   import pipe_cpu_pkg::*;
#(
   parameter int LAT        = LAT_DEFAULT,
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_ack_o,
   output logic [31:0] if_rdata_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_ack_o,
   output logic [31:0] dm_rdata_o,
   input  logic        flush_i,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   output logic        if_stall_o,
   output logic        dm_stall_o
);

   logic [1:0] state;
   logic [2:0] wait_cnt;
   logic [3:0] starve_cnt;
   logic       discard;
   mem_txn_t   txn;
   logic       grant_if;
   logic       grant_dm;
   logic       fetch_dead;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .if_req     (if_req_i),
      .dm_req     (dm_req_i),
      .flush      (flush_i),
      .starve_cnt (starve_cnt),
      .grant_if   (grant_if),
      .grant_dm   (grant_dm)
   );

   // A flush arriving in the very last WAIT cycle must still suppress the fetch ack.
   assign fetch_dead = discard | flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         discard    <= 1'b0;
         txn        <= '0;
         if_ack_o   <= 1'b0;
         dm_ack_o   <= 1'b0;
         if_rdata_o <= '0;
         dm_rdata_o <= '0;
      end else begin
         if_ack_o <= 1'b0;
         dm_ack_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_if | grant_dm) begin
                  state     <= ST_ISSUE;
                  discard   <= 1'b0;
                  txn.is_dm <= grant_dm;
                  txn.we    <= grant_dm & dm_we_i;
                  txn.addr  <= grant_dm ? dm_addr_i : if_addr_i;
                  txn.wdata <= grant_dm ? dm_wdata_i : '0;
                  // Starvation only accrues while a live (unflushed) fetch is waiting.
                  if (grant_if || !if_req_i) begin
                     starve_cnt <= '0;
                  end else if (!flush_i && starve_cnt != 4'(STARVE_MAX)) begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
               end
            end
            ST_ISSUE: begin
               state    <= ST_WAIT;
               wait_cnt <= '0;
               if (flush_i && !txn.is_dm) begin
                  discard <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (flush_i && !txn.is_dm) begin
                  discard <= 1'b1;
               end
               if (wait_cnt == 3'(LAT - 1)) begin
                  state <= ST_RESP;
                  if (txn.is_dm) begin
                     dm_ack_o   <= 1'b1;
                     dm_rdata_o <= txn.we ? 32'd0 : mem_rdata_i;
                  end else if (!fetch_dead) begin
                     if_ack_o   <= 1'b1;
                     if_rdata_o <= mem_rdata_i;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_en_o    = (state == ST_ISSUE);
   assign mem_we_o    = (state == ST_ISSUE) & txn.we;
   assign mem_addr_o  = txn.addr;
   assign mem_wdata_o = txn.wdata;

   assign if_stall_o = if_req_i & ~if_ack_o;
   assign dm_stall_o = dm_req_i & ~dm_ack_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

   localparam int LAT  = 2;
   localparam int SMAX = 2;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_ack_o;
   logic [31:0] if_rdata_o;
   logic        dm_req_i;
   logic        dm_we_i;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic        dm_ack_o;
   logic [31:0] dm_rdata_o;
   logic        flush_i;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        if_stall_o;
   logic        dm_stall_o;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(
      .LAT        (LAT),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_ack_o    (if_ack_o),
      .if_rdata_o  (if_rdata_o),
      .dm_req_i    (dm_req_i),
      .dm_we_i     (dm_we_i),
      .dm_addr_i   (dm_addr_i),
      .dm_wdata_i  (dm_wdata_i),
      .dm_ack_o    (dm_ack_o),
      .dm_rdata_o  (dm_rdata_o),
      .flush_i     (flush_i),
      .mem_en_o    (mem_en_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .if_stall_o  (if_stall_o),
      .dm_stall_o  (dm_stall_o)
   );

   // Memory device: read data is valid only in the cycle LAT after the strobe,
   // random garbage otherwise, so a mistimed capture is caught.
   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];
   logic        hist_v  [0:LAT-1];
   logic [31:0] hist_a  [0:LAT-1];
   bit          mem_ready = 1'b0;

   always @(negedge clk_i) begin
      if (!mem_ready) begin
         for (int i = 0; i < 64; i++) mem[i] = ref_mem[i];
         for (int i = 0; i < LAT; i++) begin
            hist_v[i] = 1'b0;
            hist_a[i] = '0;
         end
         mem_ready = 1'b1;
      end
      if (mem_en_o === 1'b1 && mem_we_o === 1'b1) mem[mem_addr_o[7:2]] = mem_wdata_o;
      for (int i = LAT - 1; i > 0; i--) begin
         hist_v[i] = hist_v[i-1];
         hist_a[i] = hist_a[i-1];
      end
      hist_v[0] = (mem_en_o === 1'b1) && (mem_we_o !== 1'b1);
      hist_a[0] = mem_addr_o;
   end

   always @(posedge clk_i) begin
      #1;
      if (mem_ready && hist_v[LAT-1]) mem_rdata_i = mem[hist_a[LAT-1][7:2]];
      else mem_rdata_i = $urandom;
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   bit          rst_prev = 1'b1;

   bit          busy      = 1'b0;
   int          s_cyc     = 0;
   int          next_free = 0;
   bit          txn_dm, txn_we, discard;
   logic [31:0] txn_addr, txn_wdata;
   int          starve    = 0;
   logic [31:0] exp_if_rd = '0;
   logic [31:0] exp_dm_rd = '0;
   bit          exp_if_ack = 1'b0;
   bit          exp_dm_ack = 1'b0;

   int          obs_if_ack_cyc = -1;
   int          obs_dm_ack_cyc = -1;
   int          obs_en_cyc     = -1;
   logic [31:0] obs_en_addr    = '0;
   logic [31:0] obs_dm_rdata   = '0;
   int          we_count       = 0;
   int          if_ack_cnt     = 0;
   int          dm_ack_cnt     = 0;
   int          ack_n          = 0;
   logic [5:0]  order_bits     = '0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // Advance to the next cycle and check registered outputs against the model.
   task automatic step();
      bit resp;
      @(posedge clk_i);
      #2;
      cyc++;
      if (rst_prev) begin
         busy = 1'b0; starve = 0; next_free = cyc;
         exp_if_rd = '0; exp_dm_rd = '0;
         exp_if_ack = 1'b0; exp_dm_ack = 1'b0;
         checkOutput("rst_if_ack", if_ack_o, 0);
         checkOutput("rst_dm_ack", dm_ack_o, 0);
         checkOutput("rst_if_rdata", if_rdata_o, 0);
         checkOutput("rst_dm_rdata", dm_rdata_o, 0);
         checkOutput("rst_mem_en", mem_en_o, 0);
         checkOutput("rst_mem_we", mem_we_o, 0);
         checkOutput("rst_mem_addr", mem_addr_o, 0);
         checkOutput("rst_mem_wdata", mem_wdata_o, 0);
      end else begin
         checkOutput("mem_en", mem_en_o, 32'(busy && cyc == s_cyc + 1));
         checkOutput("mem_we", mem_we_o, 32'(busy && cyc == s_cyc + 1 && txn_we));
         if (busy && cyc == s_cyc + 1) begin
            checkOutput("mem_addr", mem_addr_o, txn_addr);
            if (txn_we) checkOutput("mem_wdata", mem_wdata_o, txn_wdata);
         end
         resp = busy && (cyc == s_cyc + LAT + 2);
         exp_if_ack = resp && !txn_dm && !discard;
         exp_dm_ack = resp && txn_dm;
         if (exp_if_ack) exp_if_rd = ref_mem[txn_addr[7:2]];
         if (exp_dm_ack) exp_dm_rd = txn_we ? 32'd0 : ref_mem[txn_addr[7:2]];
         if (resp) busy = 1'b0;
         checkOutput("if_ack", if_ack_o, 32'(exp_if_ack));
         checkOutput("dm_ack", dm_ack_o, 32'(exp_dm_ack));
         checkOutput("if_rdata", if_rdata_o, exp_if_rd);
         checkOutput("dm_rdata", dm_rdata_o, exp_dm_rd);
      end
      if (if_ack_o === 1'b1) begin
         obs_if_ack_cyc = cyc; if_ack_cnt++;
      end
      if (dm_ack_o === 1'b1) begin
         obs_dm_ack_cyc = cyc; dm_ack_cnt++; obs_dm_rdata = dm_rdata_o;
      end
      if ((if_ack_o === 1'b1 || dm_ack_o === 1'b1) && ack_n < 6) begin
         order_bits = {order_bits[4:0], if_ack_o === 1'b1};
         ack_n++;
      end
      if (mem_en_o === 1'b1) begin
         obs_en_cyc = cyc; obs_en_addr = mem_addr_o;
      end
      if (mem_we_o === 1'b1) we_count++;
      if (exp_if_ack) if_req_i = 1'b0;
      if (exp_dm_ack) dm_req_i = 1'b0;
   endtask

   // After inputs for this cycle are driven: check stalls, apply the arbitration rules.
   task automatic applyStimulus();
      #1;
      checkOutput("if_stall", if_stall_o, 32'(if_req_i & ~exp_if_ack));
      checkOutput("dm_stall", dm_stall_o, 32'(dm_req_i & ~exp_dm_ack));
      rst_prev = rst_i;
      if (rst_i) return;
      if (busy && !txn_dm && flush_i && cyc >= s_cyc + 1 && cyc <= s_cyc + LAT + 1) discard = 1'b1;
      if (!busy && cyc >= next_free && ((if_req_i && !flush_i) || dm_req_i)) begin
         busy = 1'b1; s_cyc = cyc; next_free = cyc + LAT + 3; discard = 1'b0;
         if (if_req_i && !flush_i && (!dm_req_i || starve == SMAX)) begin
            txn_dm = 1'b0; txn_we = 1'b0; txn_addr = if_addr_i; txn_wdata = '0;
            starve = 0;
         end else begin
            txn_dm = 1'b1; txn_we = dm_we_i; txn_addr = dm_addr_i; txn_wdata = dm_wdata_i;
            if (!if_req_i) starve = 0;
            else if (!flush_i && starve < SMAX) starve++;
            if (dm_we_i) ref_mem[dm_addr_i[7:2]] = dm_wdata_i;
         end
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         applyStimulus();
      end
   endtask

   initial begin
      int t0;
      int cnt0;
      for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
      rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
      dm_addr_i = '0; dm_wdata_i = '0; flush_i = 1'b0;

      // Reset state.
      tick(2);
      step(); rst_i = 1'b0; applyStimulus();

      // Single fetch: strobe one cycle later, ack LAT+2 after sampling.
      step(); if_req_i = 1'b1; if_addr_i = 32'h10; applyStimulus();
      t0 = cyc;
      tick(5);
      checkOutput("fetch_en_cycle", 32'(obs_en_cyc - t0), 1);
      checkOutput("fetch_en_addr", obs_en_addr, 32'h10);
      checkOutput("fetch_ack_cycle", 32'(obs_if_ack_cyc - t0), 4);

      // Simultaneous requests: data first, then fetch.
      step(); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40; if_req_i = 1'b1; if_addr_i = 32'h8;
      applyStimulus();
      t0 = cyc;
      tick(10);
      checkOutput("both_dm_ack_cycle", 32'(obs_dm_ack_cyc - t0), 4);
      checkOutput("both_if_en_cycle", 32'(obs_en_cyc - t0), 6);
      checkOutput("both_if_en_addr", obs_en_addr, 32'h8);
      checkOutput("both_if_ack_cycle", 32'(obs_if_ack_cyc - t0), 9);

      // Continuous contention: starvation override every third grant.
      ack_n = 0;
      step(); if_req_i = 1'b1; dm_req_i = 1'b1; applyStimulus();
      for (int i = 0; i < 30; i++) begin
         step();
         if (!dm_req_i) begin
            dm_we_i = 1'($urandom); dm_addr_i = 32'($urandom_range(0, 63)) << 2; dm_wdata_i = $urandom;
         end
         if (!if_req_i) if_addr_i = 32'($urandom_range(0, 63)) << 2;
         if_req_i = 1'b1; dm_req_i = 1'b1;
         applyStimulus();
      end
      checkOutput("grant_order", 32'(order_bits), 32'(6'b001001));
      tick(15);

      // Flushed fetch: no ack, arbiter idle again five cycles after sampling.
      cnt0 = if_ack_cnt;
      step(); if_req_i = 1'b1; if_addr_i = 32'h30; applyStimulus();
      t0 = cyc;
      tick(1);
      step(); flush_i = 1'b1; if_req_i = 1'b0; applyStimulus();
      step(); flush_i = 1'b0; applyStimulus();
      tick(1);
      step(); if_req_i = 1'b1; if_addr_i = 32'h34; applyStimulus();
      tick(5);
      checkOutput("flush_next_en_cycle", 32'(obs_en_cyc - t0), 6);
      checkOutput("flush_next_en_addr", obs_en_addr, 32'h34);
      checkOutput("flush_next_ack_cycle", 32'(obs_if_ack_cyc - t0), 9);
      checkOutput("flush_ack_count", 32'(if_ack_cnt - cnt0), 1);

      // Data write, then read it back.
      cnt0 = we_count;
      step(); dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h20; dm_wdata_i = 32'hDEADBEEF;
      applyStimulus();
      t0 = cyc;
      tick(5);
      checkOutput("write_we_pulses", 32'(we_count - cnt0), 1);
      checkOutput("write_ack_cycle", 32'(obs_dm_ack_cyc - t0), 4);
      checkOutput("write_ack_rdata", obs_dm_rdata, 32'h0);
      step(); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20; applyStimulus();
      tick(5);
      checkOutput("readback_rdata", obs_dm_rdata, 32'hDEADBEEF);

      // Reset during WAIT of a read aborts it without an ack.
      cnt0 = dm_ack_cnt;
      step(); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h44; applyStimulus();
      tick(1);
      step(); rst_i = 1'b1; dm_req_i = 1'b0; applyStimulus();
      step(); rst_i = 1'b0; applyStimulus();
      tick(6);
      checkOutput("reset_abort_acks", 32'(dm_ack_cnt - cnt0), 0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         step();
         if (!if_req_i && $urandom_range(0, 2) == 0) begin
            if_req_i = 1'b1; if_addr_i = 32'($urandom_range(0, 63)) << 2;
         end
         if (!dm_req_i && $urandom_range(0, 2) == 0) begin
            dm_req_i = 1'b1; dm_we_i = 1'($urandom); dm_addr_i = 32'($urandom_range(0, 63)) << 2;
            dm_wdata_i = $urandom;
         end
         flush_i = ($urandom_range(0, 7) == 0);
         applyStimulus();
      end
      step(); flush_i = 1'b0; applyStimulus();
      tick(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
